// File: rtl/acc_pkg.sv
// Shared types and constants for the accelerator command arbiter.
//   data_t     : rs1/rs2/response data word
//   instr_t    : accelerator command instruction
//   reg_addr_t : destination register address (rd)
//   req_id_t   : requester index carried in the tag FIFO
//   XD_BIT     : instruction bit that marks a command expecting a response
package acc_pkg;

    localparam int unsigned ACC_DATA_W      = 64;
    localparam int unsigned ACC_INSTR_W     = 32;
    localparam int unsigned ACC_REG_ADDR_W  = 5;
    localparam int unsigned ACC_NUM_REQ     = 2;

    // A command writes rd (and so returns a response) when this bit is set.
    localparam int unsigned XD_BIT = 14;

    typedef logic [ACC_DATA_W-1:0]             data_t;
    typedef logic [ACC_INSTR_W-1:0]            instr_t;
    typedef logic [ACC_REG_ADDR_W-1:0]         reg_addr_t;
    typedef logic [$clog2(ACC_NUM_REQ)-1:0]    req_id_t;

endpackage

// File: rtl/acc_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per outstanding response.
// Ports:
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   push_i, push_data_i : enqueue a requester ID (ignored when full)
//   pop_i          : dequeue the head (ignored when empty)
//   head_o         : ID at the head of the queue
//   full_o, empty_o, count_o : occupancy status
module acc_tag_fifo import acc_pkg::*; #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_eff;
    logic             pop_eff;

    assign full_o   = (count == CNT_W'(DEPTH));
    assign empty_o  = (count == '0);
    assign count_o  = count;
    assign head_o   = mem[rd_ptr];
    assign push_eff = push_i && !full_o;
    assign pop_eff  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_eff)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_eff) mem[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/acc_cmd_arbiter.sv
// Shares one accelerator among NumReq requesters.
// Commands are round-robin arbitrated into a registered accelerator command
// port; each command with xd set records its requester ID in an in-order tag
// FIFO, whose head steers the (combinational) response path back.
// Ports:
//   clk_i, rst_i                       : clock, asynchronous active-high reset
//   req_cmd_valid_i / req_cmd_ready_o  : per-requester command handshake
//   req_cmd_inst_i/rs1_i/rs2_i         : per-requester command payload
//   req_resp_valid_o / req_resp_ready_i: per-requester response handshake
//   req_resp_data_o, req_resp_rd_o     : response payload, broadcast
//   acc_cmd_*                          : accelerator command port (registered)
//   acc_resp_*                         : accelerator response port
//   outstanding_o                      : tag FIFO occupancy
//   busy_o                             : command pending or tags outstanding
//   spurious_resp_o                    : pulse after a response with no tag
module acc_cmd_arbiter import acc_pkg::*; #(
    parameter int unsigned NumReq             = 2,
    parameter int unsigned ACC_DATA_WIDTH     = 64,
    parameter int unsigned ACC_INSTR_WIDTH    = 32,
    parameter int unsigned ACC_REG_ADDR_WIDTH = 5,
    parameter int unsigned MaxOutstanding     = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic [NumReq-1:0]                           req_cmd_valid_i,
    output logic [NumReq-1:0]                           req_cmd_ready_o,
    input  logic [NumReq-1:0][ACC_INSTR_WIDTH-1:0]      req_cmd_inst_i,
    input  logic [NumReq-1:0][ACC_DATA_WIDTH-1:0]       req_cmd_rs1_i,
    input  logic [NumReq-1:0][ACC_DATA_WIDTH-1:0]       req_cmd_rs2_i,
    output logic [NumReq-1:0]                           req_resp_valid_o,
    input  logic [NumReq-1:0]                           req_resp_ready_i,
    output logic [ACC_DATA_WIDTH-1:0]                   req_resp_data_o,
    output logic [ACC_REG_ADDR_WIDTH-1:0]               req_resp_rd_o,
    output logic                                        acc_cmd_valid_o,
    input  logic                                        acc_cmd_ready_i,
    output logic [ACC_INSTR_WIDTH-1:0]                  acc_cmd_inst_o,
    output logic [ACC_DATA_WIDTH-1:0]                   acc_cmd_rs1_o,
    output logic [ACC_DATA_WIDTH-1:0]                   acc_cmd_rs2_o,
    input  logic                                        acc_resp_valid_i,
    output logic                                        acc_resp_ready_o,
    input  logic [ACC_DATA_WIDTH-1:0]                   acc_resp_data_i,
    input  logic [ACC_REG_ADDR_WIDTH-1:0]               acc_resp_rd_i,
    output logic [$clog2(MaxOutstanding):0]             outstanding_o,
    output logic                                        busy_o,
    output logic                                        spurious_resp_o
);

    localparam int unsigned ID_W  = $clog2(NumReq);
    localparam int unsigned CNT_W = $clog2(MaxOutstanding) + 1;

    logic [ID_W-1:0]            rr;
    logic [NumReq-1:0]          elig;
    logic                       slot_free;
    logic                       grant_vld_p0;
    logic [ID_W-1:0]            grant_id_p0;
    logic [ID_W-1:0]            scan_id;
    logic                       grant_xd_p0;

    logic                       cmd_vld_p1;
    logic [ACC_INSTR_WIDTH-1:0] cmd_inst_p1;
    logic [ACC_DATA_WIDTH-1:0]  cmd_rs1_p1;
    logic [ACC_DATA_WIDTH-1:0]  cmd_rs2_p1;
    logic                       spurious_p1;

    logic                       tag_push;
    logic                       tag_pop;
    logic [ID_W-1:0]            tag_head;
    logic                       tag_full;
    logic                       tag_empty;
    logic [CNT_W-1:0]           tag_count;

    // ---- stage p0: eligibility and round-robin grant ----
    assign slot_free = !cmd_vld_p1 || acc_cmd_ready_i;

    // Eligibility is judged on the registered (pre-pop) occupancy, so a
    // response popping this cycle never opens room for an xd push this cycle.
    for (genvar k = 0; k < NumReq; k++) begin : g_elig
        assign elig[k] = req_cmd_valid_i[k] && slot_free &&
                         (!req_cmd_inst_i[k][XD_BIT] || !tag_full);
    end

    always_comb begin
        grant_vld_p0 = 1'b0;
        grant_id_p0  = '0;
        scan_id      = '0;
        for (int i = 0; i < int'(NumReq); i++) begin
            // Candidate index (rr + i) mod NumReq, without a modulo operator.
            if (int'(rr) + i >= int'(NumReq)) scan_id = ID_W'(int'(rr) + i - int'(NumReq));
            else                              scan_id = ID_W'(int'(rr) + i);
            if (!grant_vld_p0 && elig[scan_id]) begin
                grant_vld_p0 = 1'b1;
                grant_id_p0  = scan_id;
            end
        end
    end

    assign req_cmd_ready_o = grant_vld_p0 ? (NumReq'(1) << grant_id_p0) : '0;
    assign grant_xd_p0     = req_cmd_inst_i[grant_id_p0][XD_BIT];
    assign tag_push        = grant_vld_p0 && grant_xd_p0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr <= '0;
        end else if (grant_vld_p0) begin
            if (grant_id_p0 == ID_W'(NumReq - 1)) rr <= '0;
            else                                  rr <= grant_id_p0 + ID_W'(1);
        end
    end

    // ---- stage p1: registered accelerator command slot ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_vld_p1  <= 1'b0;
            cmd_inst_p1 <= '0;
            cmd_rs1_p1  <= '0;
            cmd_rs2_p1  <= '0;
        end else if (grant_vld_p0) begin
            cmd_vld_p1  <= 1'b1;
            cmd_inst_p1 <= req_cmd_inst_i[grant_id_p0];
            cmd_rs1_p1  <= req_cmd_rs1_i[grant_id_p0];
            cmd_rs2_p1  <= req_cmd_rs2_i[grant_id_p0];
        end else if (acc_cmd_ready_i) begin
            cmd_vld_p1  <= 1'b0;
        end
    end

    assign acc_cmd_valid_o = cmd_vld_p1;
    assign acc_cmd_inst_o  = cmd_inst_p1;
    assign acc_cmd_rs1_o   = cmd_rs1_p1;
    assign acc_cmd_rs2_o   = cmd_rs2_p1;

    // ---- response routing (combinational, steered by the FIFO head) ----
    always_comb begin
        req_resp_valid_o = '0;
        // With no tag outstanding the response is swallowed.
        acc_resp_ready_o = 1'b1;
        if (!tag_empty) begin
            req_resp_valid_o[tag_head] = acc_resp_valid_i;
            acc_resp_ready_o           = req_resp_ready_i[tag_head];
        end
    end

    assign req_resp_data_o = acc_resp_data_i;
    assign req_resp_rd_o   = acc_resp_rd_i;
    assign tag_pop         = acc_resp_valid_i && acc_resp_ready_o && !tag_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) spurious_p1 <= 1'b0;
        else       spurious_p1 <= acc_resp_valid_i && tag_empty;
    end

    acc_tag_fifo #(
        .DEPTH (MaxOutstanding),
        .W     (ID_W)
    ) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (tag_push),
        .push_data_i (grant_id_p0),
        .pop_i       (tag_pop),
        .head_o      (tag_head),
        .full_o      (tag_full),
        .empty_o     (tag_empty),
        .count_o     (tag_count)
    );

    assign outstanding_o   = tag_count;
    assign busy_o          = cmd_vld_p1 || (tag_count != '0);
    assign spurious_resp_o = spurious_p1;

endmodule

// File: tb/tb_acc_cmd_arbiter.sv
module tb_acc_cmd_arbiter;

    logic              clk = 1'b0;
    logic              rst_i;
    logic [1:0]        req_cmd_valid_i;
    logic [1:0]        req_cmd_ready_o;
    logic [1:0][31:0]  req_cmd_inst_i;
    logic [1:0][63:0]  req_cmd_rs1_i;
    logic [1:0][63:0]  req_cmd_rs2_i;
    logic [1:0]        req_resp_valid_o;
    logic [1:0]        req_resp_ready_i;
    logic [63:0]       req_resp_data_o;
    logic [4:0]        req_resp_rd_o;
    logic              acc_cmd_valid_o;
    logic              acc_cmd_ready_i;
    logic [31:0]       acc_cmd_inst_o;
    logic [63:0]       acc_cmd_rs1_o;
    logic [63:0]       acc_cmd_rs2_o;
    logic              acc_resp_valid_i;
    logic              acc_resp_ready_o;
    logic [63:0]       acc_resp_data_i;
    logic [4:0]        acc_resp_rd_i;
    logic [2:0]        outstanding_o;
    logic              busy_o;
    logic              spurious_resp_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    acc_cmd_arbiter dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .req_cmd_valid_i  (req_cmd_valid_i),
        .req_cmd_ready_o  (req_cmd_ready_o),
        .req_cmd_inst_i   (req_cmd_inst_i),
        .req_cmd_rs1_i    (req_cmd_rs1_i),
        .req_cmd_rs2_i    (req_cmd_rs2_i),
        .req_resp_valid_o (req_resp_valid_o),
        .req_resp_ready_i (req_resp_ready_i),
        .req_resp_data_o  (req_resp_data_o),
        .req_resp_rd_o    (req_resp_rd_o),
        .acc_cmd_valid_o  (acc_cmd_valid_o),
        .acc_cmd_ready_i  (acc_cmd_ready_i),
        .acc_cmd_inst_o   (acc_cmd_inst_o),
        .acc_cmd_rs1_o    (acc_cmd_rs1_o),
        .acc_cmd_rs2_o    (acc_cmd_rs2_o),
        .acc_resp_valid_i (acc_resp_valid_i),
        .acc_resp_ready_o (acc_resp_ready_o),
        .acc_resp_data_i  (acc_resp_data_i),
        .acc_resp_rd_i    (acc_resp_rd_i),
        .outstanding_o    (outstanding_o),
        .busy_o           (busy_o),
        .spurious_resp_o  (spurious_resp_o)
    );

    typedef struct {
        logic [1:0]  vld;
        logic [1:0]  xd;
        logic        resp_vld;
        logic [1:0]  resp_rdy;
        logic [1:0]  e_cmd_rdy;
        logic [1:0]  e_resp_vld;
        logic        e_resp_rdy;
        logic        e_acc_vld;
        logic [31:0] e_inst;
        logic [2:0]  e_out;
    } vec_t;

    vec_t vt [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic xd, input int i, input int k);
        return (32'(xd) << 14) | (32'(i) << 4) | 32'(k);
    endfunction

    task automatic idle();
        req_cmd_valid_i  = '0;
        req_cmd_inst_i   = '0;
        req_cmd_rs1_i    = '0;
        req_cmd_rs2_i    = '0;
        req_resp_ready_i = '0;
        acc_cmd_ready_i  = 1'b1;
        acc_resp_valid_i = 1'b0;
        acc_resp_data_i  = '0;
        acc_resp_rd_i    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            vld    xd    rv    rrdy  cmd_rdy rvld  ardy  avld  inst        out
        vt[0]  = '{2'b11, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 32'h0000, 3'd0};
        vt[1]  = '{2'b11, 2'b00, 1'b0, 2'b00, 2'b10, 2'b00, 1'b1, 1'b1, 32'h0011, 3'd0};
        vt[2]  = '{2'b11, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 32'h0020, 3'd0};
        vt[3]  = '{2'b11, 2'b00, 1'b0, 2'b00, 2'b10, 2'b00, 1'b1, 1'b1, 32'h0031, 3'd0};
        vt[4]  = '{2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 32'h0031, 3'd0};
        vt[5]  = '{2'b01, 2'b01, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 32'h4050, 3'd1};
        vt[6]  = '{2'b10, 2'b10, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 32'h4061, 3'd2};
        vt[7]  = '{2'b11, 2'b11, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 32'h4070, 3'd3};
        vt[8]  = '{2'b11, 2'b11, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 32'h4081, 3'd4};
        vt[9]  = '{2'b11, 2'b01, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1, 32'h0091, 3'd4};
        vt[10] = '{2'b01, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0091, 3'd4};
        vt[11] = '{2'b01, 2'b01, 1'b1, 2'b11, 2'b00, 2'b01, 1'b1, 1'b0, 32'h0091, 3'd3};
        vt[12] = '{2'b01, 2'b01, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1, 32'h40C0, 3'd4};
        vt[13] = '{2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0, 32'h40C0, 3'd4};
        vt[14] = '{2'b00, 2'b00, 1'b1, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 32'h40C0, 3'd3};
        vt[15] = '{2'b10, 2'b10, 1'b1, 2'b11, 2'b10, 2'b01, 1'b1, 1'b1, 32'h40F1, 3'd3};

        // Reset state
        idle();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst acc_cmd_valid", 64'(acc_cmd_valid_o), 64'd0);
        check("rst acc_cmd_inst", 64'(acc_cmd_inst_o), 64'd0);
        check("rst acc_cmd_rs1", acc_cmd_rs1_o, 64'd0);
        check("rst outstanding", 64'(outstanding_o), 64'd0);
        check("rst busy", 64'(busy_o), 64'd0);
        check("rst spurious", 64'(spurious_resp_o), 64'd0);
        check("rst cmd_ready", 64'(req_cmd_ready_o), 64'd0);
        rst_i = 1'b0;

        // Single xd command from requester 0, rd = 7, then its response
        req_cmd_valid_i   = 2'b01;
        req_cmd_inst_i[0] = 32'h0000_4380;
        req_cmd_rs1_i[0]  = 64'h11;
        req_cmd_rs2_i[0]  = 64'h22;
        #4;
        check("t1 cmd_ready", 64'(req_cmd_ready_o), 64'h1);
        tick();
        check("t1 acc_cmd_valid", 64'(acc_cmd_valid_o), 64'd1);
        check("t1 acc_cmd_inst", 64'(acc_cmd_inst_o), 64'h4380);
        check("t1 acc_cmd_rs1", acc_cmd_rs1_o, 64'h11);
        check("t1 acc_cmd_rs2", acc_cmd_rs2_o, 64'h22);
        check("t1 outstanding", 64'(outstanding_o), 64'd1);
        check("t1 busy", 64'(busy_o), 64'd1);
        req_cmd_valid_i  = 2'b00;
        acc_resp_valid_i = 1'b1;
        acc_resp_data_i  = 64'hDEAD;
        acc_resp_rd_i    = 5'd7;
        req_resp_ready_i = 2'b11;
        #4;
        check("t1 resp_valid", 64'(req_resp_valid_o), 64'h1);
        check("t1 resp_data", req_resp_data_o, 64'hDEAD);
        check("t1 resp_rd", 64'(req_resp_rd_o), 64'd7);
        check("t1 acc_resp_ready", 64'(acc_resp_ready_o), 64'd1);
        tick();
        check("t1 outstanding after resp", 64'(outstanding_o), 64'd0);
        check("t1 acc_cmd_valid drained", 64'(acc_cmd_valid_o), 64'd0);
        check("t1 busy after resp", 64'(busy_o), 64'd0);
        idle();

        // Back-pressure: payload held while acc_cmd_ready_i is low (rr = 1 now)
        req_cmd_valid_i   = 2'b10;
        req_cmd_inst_i[1] = 32'h0123;
        req_cmd_rs1_i[1]  = 64'hA1;
        req_cmd_rs2_i[1]  = 64'hB2;
        #4;
        check("st grant1 cmd_ready", 64'(req_cmd_ready_o), 64'h2);
        tick();
        check("st acc_cmd_valid", 64'(acc_cmd_valid_o), 64'd1);
        acc_cmd_ready_i   = 1'b0;
        req_cmd_valid_i   = 2'b11;
        req_cmd_inst_i[0] = 32'h0456;
        req_cmd_rs1_i[0]  = 64'hC3;
        req_cmd_rs2_i[0]  = 64'hD4;
        req_cmd_inst_i[1] = 32'h0789;
        req_cmd_rs1_i[1]  = 64'hE5;
        for (int c = 0; c < 3; c++) begin
            #4;
            check($sformatf("st%0d cmd_ready", c), 64'(req_cmd_ready_o), 64'h0);
            tick();
            check($sformatf("st%0d acc_cmd_valid", c), 64'(acc_cmd_valid_o), 64'd1);
            check($sformatf("st%0d inst", c), 64'(acc_cmd_inst_o), 64'h0123);
            check($sformatf("st%0d rs1", c), acc_cmd_rs1_o, 64'hA1);
            check($sformatf("st%0d rs2", c), acc_cmd_rs2_o, 64'hB2);
        end
        acc_cmd_ready_i = 1'b1;
        #4;
        check("st release cmd_ready", 64'(req_cmd_ready_o), 64'h1);
        tick();
        check("st release inst", 64'(acc_cmd_inst_o), 64'h0456);
        check("st release rs1", acc_cmd_rs1_o, 64'hC3);
        idle();
        tick();
        check("st drained valid", 64'(acc_cmd_valid_o), 64'd0);

        // Fresh start for the vector table
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;

        for (int i = 0; i < 16; i++) begin
            req_cmd_valid_i   = vt[i].vld;
            req_cmd_inst_i[0] = mk_inst(vt[i].xd[0], i, 0);
            req_cmd_inst_i[1] = mk_inst(vt[i].xd[1], i, 1);
            acc_resp_valid_i  = vt[i].resp_vld;
            acc_resp_data_i   = 64'(i);
            req_resp_ready_i  = vt[i].resp_rdy;
            #4;
            check($sformatf("v%0d cmd_ready", i), 64'(req_cmd_ready_o), 64'(vt[i].e_cmd_rdy));
            check($sformatf("v%0d resp_valid", i), 64'(req_resp_valid_o), 64'(vt[i].e_resp_vld));
            check($sformatf("v%0d acc_resp_ready", i), 64'(acc_resp_ready_o), 64'(vt[i].e_resp_rdy));
            tick();
            check($sformatf("v%0d acc_cmd_valid", i), 64'(acc_cmd_valid_o), 64'(vt[i].e_acc_vld));
            check($sformatf("v%0d acc_cmd_inst", i), 64'(acc_cmd_inst_o), 64'(vt[i].e_inst));
            check($sformatf("v%0d outstanding", i), 64'(outstanding_o), 64'(vt[i].e_out));
        end

        // Asynchronous reset mid-operation drops the command and all tags
        idle();
        check("mid busy before reset", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        #1;
        check("mid rst acc_cmd_valid", 64'(acc_cmd_valid_o), 64'd0);
        check("mid rst outstanding", 64'(outstanding_o), 64'd0);
        check("mid rst busy", 64'(busy_o), 64'd0);
        tick();
        rst_i = 1'b0;

        // Response with no outstanding tag
        acc_resp_valid_i = 1'b1;
        acc_resp_data_i  = 64'hBEEF;
        req_resp_ready_i = 2'b00;
        #4;
        check("sp acc_resp_ready", 64'(acc_resp_ready_o), 64'd1);
        check("sp resp_valid", 64'(req_resp_valid_o), 64'd0);
        check("sp pulse early", 64'(spurious_resp_o), 64'd0);
        tick();
        check("sp pulse", 64'(spurious_resp_o), 64'd1);
        check("sp outstanding", 64'(outstanding_o), 64'd0);
        acc_resp_valid_i = 1'b0;
        tick();
        check("sp pulse end", 64'(spurious_resp_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
